// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - fixed-latency RV32M multiply/divide sequencer
// Radix-2 shift-add multiply and restoring divide, 35 cycles per op start to start.
module muldiv_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_load_regfile,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    // Op index is the op code minus 10, so bit 2 marks the divide family.
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    state_t      state;
    logic [2:0]  op;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] acc;
    logic [63:0] opa;
    logic [31:0] opb;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic        overflow;

    logic        valid_op;
    logic        is_div;
    logic        signed_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        div_fits;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] fix_result;

    assign valid_op   = (i_instruction >= 32'd10) && (i_instruction <= 32'd17);
    assign is_div     = op[2];
    assign signed_div = (op == OP_DIV) || (op == OP_REM);

    always_comb begin
        neg_a = 1'b0;
        neg_b = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                neg_a = a_reg[31];
                neg_b = b_reg[31];
            end
            OP_MULHSU: neg_a = a_reg[31];
            default: begin
                neg_a = 1'b0;
                neg_b = 1'b0;
            end
        endcase
        mag_a = neg_a ? (32'd0 - a_reg) : a_reg;
        mag_b = neg_b ? (32'd0 - b_reg) : b_reg;
    end

    // Restoring step: remainder lives in acc[31:0], dividend/quotient shifts through opb.
    always_comb begin
        rem_shift = {acc[31:0], opb[31]};
        diff      = rem_shift - {1'b0, opa[31:0]};
        div_fits  = ~diff[32];
    end

    always_comb begin
        prod       = neg_q ? (64'd0 - acc) : acc;
        quot       = neg_q ? (32'd0 - opb) : opb;
        rem        = neg_r ? (32'd0 - acc[31:0]) : acc[31:0];
        fix_result = 32'd0;
        case (op)
            OP_MUL:                       fix_result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[63:32];
            OP_DIV, OP_DIVU: begin
                if (div_zero)      fix_result = 32'hFFFF_FFFF;
                else if (overflow) fix_result = 32'h8000_0000;
                else               fix_result = quot;
            end
            OP_REM, OP_REMU: begin
                if (div_zero)      fix_result = a_reg;
                else if (overflow) fix_result = 32'd0;
                else               fix_result = rem;
            end
            default: fix_result = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_load_regfile <= 1'b0;
            o_result       <= 32'd0;
            op             <= 3'd0;
            a_reg          <= 32'd0;
            b_reg          <= 32'd0;
            acc            <= 64'd0;
            opa            <= 64'd0;
            opb            <= 32'd0;
            cnt            <= 5'd0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            div_zero       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            o_done         <= 1'b0;
            o_load_regfile <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && valid_op) begin
                        op     <= i_instruction[2:0] - 3'd2;
                        a_reg  <= i_A;
                        b_reg  <= i_B;
                        o_busy <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    if (is_div) begin
                        opa <= {32'd0, mag_b};
                        opb <= mag_a;
                    end else begin
                        opa <= {32'd0, mag_a};
                        opb <= mag_b;
                    end
                    acc      <= 64'd0;
                    cnt      <= 5'd0;
                    neg_q    <= neg_a ^ neg_b;
                    neg_r    <= neg_a;
                    div_zero <= is_div && (b_reg == 32'd0);
                    overflow <= signed_div && (a_reg == 32'h8000_0000)
                                && (b_reg == 32'hFFFF_FFFF);
                    state    <= CALC;
                end
                CALC: begin
                    if (is_div) begin
                        acc <= {32'd0, div_fits ? diff[31:0] : rem_shift[31:0]};
                        opb <= {opb[30:0], div_fits};
                    end else begin
                        if (opb[0]) begin
                            acc <= acc + opa;
                        end
                        opa <= {opa[62:0], 1'b0};
                        opb <= {1'b0, opb[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    o_result       <= fix_result;
                    o_done         <= 1'b1;
                    o_load_regfile <= 1'b1;
                    o_busy         <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        load;
    logic [31:0] result;

    int checks;
    int failures;

    muldiv_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_instruction  (instr),
        .i_A            (a_in),
        .i_B            (b_in),
        .o_busy         (busy),
        .o_done         (done),
        .o_load_regfile (load),
        .o_result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            32'd10: begin p = ua * ub; return p[31:0];  end
            32'd11: begin p = sa * sb; return p[63:32]; end
            32'd12: begin p = sa * ub; return p[63:32]; end
            32'd13: begin p = ua * ub; return p[63:32]; end
            32'd14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            32'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            32'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            32'd17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Issues one op and records what happened; operands on the bus are scrambled while busy.
    task automatic do_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int repulse_at, output logic [31:0] res, output int lat,
                         output bit busy_ok, output bit load_ok, output bit hold_ok);
        busy_ok = 1'b1;
        load_ok = 1'b1;
        hold_ok = 1'b0;
        lat     = -1;
        start = 1'b1; instr = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            start = (n == repulse_at);
            instr = 32'($urandom_range(10, 17));
            a_in  = $urandom;
            b_in  = $urandom;
            @(posedge clk); #1;
            if (load !== done) load_ok = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        res = result;
        if (lat > 0) begin
            @(posedge clk); #1;
            hold_ok = (done === 1'b0) && (load === 1'b0) && (busy === 1'b0) && (result === res);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; instr = 32'd0; a_in = 32'd0; b_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (load !== 1'b0)    begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] ops [14] = '{10, 11, 13, 12, 14, 16, 15, 17, 15, 17, 14, 16, 10, 11};
        logic [31:0] as  [14] = '{7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 100, 100, 5, 5,
                                  32'h8000_0000, 32'h8000_0000, 6, 32'h7FFF_FFFF};
        logic [31:0] bs  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  2, 2, 7, 7, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 32'h7FFF_FFFF};
        logic [31:0] ex  [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 14, 2, 32'hFFFF_FFFF, 5,
                                  32'h8000_0000, 0, 42, 32'h3FFF_FFFF};
        logic [31:0] res;
        int lat;
        bit bok, lok, hok;
        for (int i = 0; i < 14; i++) begin
            do_op(ops[i], as[i], bs[i], 0, res, lat, bok, lok, hok);
            checks += 5;
            if (res !== ex[i]) begin
                failures++; $display("FAIL dir%0d_result op=%0d got=%h exp=%h", i, ops[i], res, ex[i]);
            end
            if (lat != 34) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=34", i, lat); end
            if (!bok) begin failures++; $display("FAIL dir%0d_busy got=bad exp=high E0..E33 low at E34", i); end
            if (!lok) begin failures++; $display("FAIL dir%0d_load got=differs exp=equal to done", i); end
            if (!hok) begin failures++; $display("FAIL dir%0d_hold got=bad exp=done low, result held", i); end
        end
    endtask

    task automatic test_random;
        logic [31:0] corners [6] = '{0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 2};
        logic [31:0] op, a, b, res, exp;
        int lat;
        bit bok, lok, hok;
        for (int i = 0; i < 40; i++) begin
            op = 32'($urandom_range(10, 17));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            exp = model(op, a, b);
            do_op(op, a, b, 0, res, lat, bok, lok, hok);
            checks += 2;
            if (res !== exp) begin
                failures++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp);
            end
            if (lat != 34 || !bok || !lok) begin
                failures++; $display("FAIL rand%0d_timing got=lat %0d busy %0b load %0b exp=lat 34 ok", i, lat, bok, lok);
            end
        end
    endtask

    task automatic test_bad_op;
        logic [31:0] bad [5] = '{3, 0, 9, 18, 32'hFFFF_FFFF};
        bit seen;
        for (int i = 0; i < 5; i++) begin
            seen = 1'b0;
            start = 1'b1; instr = bad[i]; a_in = $urandom; b_in = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (busy !== 1'b0 || done !== 1'b0 || load !== 1'b0) seen = 1'b1;
                @(posedge clk); #1;
            end
            checks++;
            if (seen) begin failures++; $display("FAIL badop_%0d got=activity exp=none", bad[i]); end
        end
    endtask

    task automatic test_repulse;
        logic [31:0] res;
        int lat;
        bit bok, lok, hok;
        do_op(32'd10, 32'd123456, 32'd789, 10, res, lat, bok, lok, hok);
        checks += 2;
        if (res !== 32'd97406784) begin failures++; $display("FAIL repulse_result got=%h exp=%h", res, 32'd97406784); end
        if (lat != 34) begin failures++; $display("FAIL repulse_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int lat;
        bit bok, lok, hok, seen;
        do_op(32'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bok, lok, hok);
        start = 1'b1; instr = 32'd14; a_in = 32'd1000; b_in = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 4;
        if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (load !== 1'b0)    begin failures++; $display("FAIL midrst_load got=%b exp=0", load); end
        if (result !== 32'd0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL midrst_quiet got=activity exp=none"); end
        do_op(32'd10, 32'd6, 32'd7, 0, res, lat, bok, lok, hok);
        checks++;
        if (res !== 32'd42 || lat != 34) begin
            failures++; $display("FAIL midrst_fresh got=%0d lat %0d exp=42 lat 34", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2;
        int lat1, lat2;
        lat1 = -1; lat2 = -1; r1 = 32'd0; r2 = 32'd0;
        start = 1'b1; instr = 32'd15; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat1 = n; r1 = result; break; end
        end
        instr = 32'd17;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=busy %b exp=1", busy); end
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat2 = n; r2 = result; break; end
        end
        checks += 2;
        if (lat1 != 34 || lat2 != 34) begin
            failures++; $display("FAIL b2b_latency got=%0d,%0d exp=34,34", lat1, lat2);
        end
        if (r1 !== 32'd14 || r2 !== 32'd2) begin
            failures++; $display("FAIL b2b_results got=%0d,%0d exp=14,2", r1, r2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; instr = 32'd0; a_in = 32'd0; b_in = 32'd0;
        test_reset;
        test_directed;
        test_random;
        test_bad_op;
        test_repulse;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
